// File: rtl/map_sst_pkg.sv
// map_sst_pkg: shared types and constants for the mapper save-state master.
// Optional verify pass is compiled in with macro SST_VERIFY_EN.
`timescale 1ns/1ps
package map_sst_pkg;

  // Number of mapper registers mirrored into the state buffer.
  localparam int SST_REG_CNT  = 128;
  // Index of the read-only map_idx register; saved but never restored.
  localparam int SST_IDX_ADDR = 127;

  // Terminal index values for the save and load/verify walks.
  localparam logic [6:0] IDX_LAST_SAVE = 7'(SST_REG_CNT - 1);
  localparam logic [6:0] IDX_LAST_LOAD = 7'(SST_IDX_ADDR - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SAVE_SET,
    ST_SAVE_CAP,
    ST_LOAD_RD,
    ST_LOAD_WR,
`ifdef SST_VERIFY_EN
    ST_VFY_RD,
    ST_VFY_SET,
    ST_VFY_CMP,
`endif
    ST_FIN
  } sst_state_e;

endpackage

// File: rtl/map_sst_master.sv
// map_sst_master: walks the mapper register file through the save-state bus,
// dumping it into a state buffer (save) or restoring it from there (load).
// Defining SST_VERIFY_EN adds a read-back verify pass after every load.
`timescale 1ns/1ps
module map_sst_master
  import map_sst_pkg::*;
(
  input  logic       clk,
  input  logic       map_rst,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  input  logic       cpu_m3,
  output logic       sst_act,
  output logic       sst_we_reg,
  output logic [7:0] sst_addr,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_di,
  input  logic [7:0] buf_do,
  output logic       vfy_err
);

  sst_state_e state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic       act_q, act_d;
  logic       done_q, done_d;
  logic       sst_we_q, sst_we_d;
  logic [7:0] addr_q, addr_d;
  logic       buf_we_q, buf_we_d;
  logic [7:0] buf_di_q, buf_di_d;
  logic [7:0] sst_dato_q, sst_dato_d;
`ifdef SST_VERIFY_EN
  logic       vfy_err_q, vfy_err_d;
`endif

  // Sequencer: next state and index, plus the sticky verify flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef SST_VERIFY_EN
    vfy_err_d = vfy_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (cmd_save) begin
          state_d = ST_SAVE_SET;
        end else if (cmd_load) begin
          state_d = ST_LOAD_RD;
`ifdef SST_VERIFY_EN
          vfy_err_d = 1'b0;
`endif
        end
      end
      ST_SAVE_SET: state_d = ST_SAVE_CAP;
      ST_SAVE_CAP: begin
        if (idx_q == IDX_LAST_SAVE) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_SAVE_SET;
          idx_d   = idx_q + 7'd1;
        end
      end
      ST_LOAD_RD: state_d = ST_LOAD_WR;
      ST_LOAD_WR: begin
        // The mapper only latches on an m3 tick, so hold the write until one.
        if (cpu_m3) begin
          if (idx_q == IDX_LAST_LOAD) begin
`ifdef SST_VERIFY_EN
            state_d = ST_VFY_RD;
            idx_d   = '0;
`else
            state_d = ST_FIN;
`endif
          end else begin
            state_d = ST_LOAD_RD;
            idx_d   = idx_q + 7'd1;
          end
        end
      end
`ifdef SST_VERIFY_EN
      ST_VFY_RD:  state_d = ST_VFY_SET;
      ST_VFY_SET: state_d = ST_VFY_CMP;
      ST_VFY_CMP: begin
        if (sst_di != buf_do) vfy_err_d = 1'b1;
        if (idx_q == IDX_LAST_LOAD) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_VFY_RD;
          idx_d   = idx_q + 7'd1;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop.
  always_comb begin
    act_d    = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FIN);
    sst_we_d = (state_d == ST_LOAD_WR);
    buf_we_d = (state_d == ST_SAVE_CAP);
    addr_d   = act_d ? {1'b0, idx_d} : 8'h00;
    // Entering SAVE_CAP the address has settled for a full cycle, so
    // sst_di already belongs to the current index.
    buf_di_d = (state_d == ST_SAVE_CAP) ? sst_di : 8'h00;
    // Buffer data arrives in the first LOAD_WR cycle; keep it afterwards.
    sst_dato_d = (state_q == ST_LOAD_WR) ? buf_do : sst_dato_q;
  end

  // State, index and registered outputs.
  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      act_q      <= 1'b0;
      done_q     <= 1'b0;
      sst_we_q   <= 1'b0;
      addr_q     <= 8'h00;
      buf_we_q   <= 1'b0;
      buf_di_q   <= 8'h00;
      sst_dato_q <= 8'h00;
`ifdef SST_VERIFY_EN
      vfy_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      done_q     <= done_d;
      sst_we_q   <= sst_we_d;
      addr_q     <= addr_d;
      buf_we_q   <= buf_we_d;
      buf_di_q   <= buf_di_d;
      sst_dato_q <= sst_dato_d;
`ifdef SST_VERIFY_EN
      vfy_err_q  <= vfy_err_d;
`endif
    end
  end

  assign busy       = act_q;
  assign sst_act    = act_q;
  assign done       = done_q;
  assign sst_we_reg = sst_we_q;
  assign sst_addr   = addr_q;
  assign buf_addr   = addr_q;
  assign buf_we     = buf_we_q;
  assign buf_di     = buf_di_q;
  // The buffer address is held through LOAD_WR, so buf_do is steady there
  // and can be shown from the first write cycle on.
  assign sst_dato   = (state_q == ST_LOAD_WR) ? buf_do : sst_dato_q;
`ifdef SST_VERIFY_EN
  assign vfy_err    = vfy_err_q;
`else
  assign vfy_err    = 1'b0;
`endif

endmodule

// File: tb/tb_map_sst_master.sv
// tb_map_sst_master: directed bench for map_sst_master with a stub mapper,
// a stub state buffer and a per-cycle checker of the save/load rules.
`timescale 1ns/1ps
module tb_map_sst_master;

  logic       clk = 1'b0;
  logic       map_rst, cmd_save, cmd_load, cpu_m3;
  logic       busy, done, sst_act, sst_we_reg, buf_we, vfy_err;
  logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_di, buf_do;

  always #5 clk = ~clk;

  map_sst_master dut (
    .clk(clk), .map_rst(map_rst), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .busy(busy), .done(done), .cpu_m3(cpu_m3), .sst_act(sst_act),
    .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_di(sst_di), .buf_addr(buf_addr), .buf_we(buf_we), .buf_di(buf_di),
    .buf_do(buf_do), .vfy_err(vfy_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_total = 0;
  int work_total = 0;
  int m3_mode = 1;      // 0: one cycle in four, 1: low, 2: high
  int fill_mode = 2;    // buffer pattern: 0: i, 1: i^33, 2: zero
  bit save_mode = 1'b0; // stub mapper reads addr^5A when set
  bit corrupt = 1'b0;   // stub mapper inverts reads of reg 9
  bit mon_en = 1'b0;
  bit fill_req = 1'b0;
  bit map_clr = 1'b0;

  logic [7:0] buf_mem [0:255];
  logic [7:0] map_regs [0:127];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  function automatic logic [7:0] exp_buf(input logic [7:0] a);
    case (fill_mode)
      0:       return a;
      1:       return a ^ 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stub state buffer: registered read, write port for the master.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) buf_mem[i] <= exp_buf(8'(i));
    end else if (buf_we) begin
      buf_mem[buf_addr] <= buf_di;
    end
    buf_do <= buf_mem[buf_addr];
  end

  // Stub mapper: latches writes on m3 ticks and logs each one.
  always @(posedge clk) begin
    if (map_clr) begin
      for (int i = 0; i < 128; i++) map_regs[i] <= 8'hC3;
    end else if (sst_we_reg && cpu_m3) begin
      map_regs[sst_addr[6:0]] <= sst_dato;
      wr_addr_q.push_back(sst_addr);
      wr_data_q.push_back(sst_dato);
      $display("mapper write addr=%0d data=%02h at %0t", sst_addr, sst_dato, $time);
    end
  end

  always_comb begin
    if (save_mode) begin
      sst_di = sst_addr ^ 8'h5A;
    end else begin
      sst_di = map_regs[sst_addr[6:0]];
      if (corrupt && sst_addr == 8'd9) sst_di = sst_di ^ 8'hFF;
    end
  end

  // m3 tick generator, updated well clear of the clock edges.
  initial begin
    int m3_cnt = 0;
    cpu_m3 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m3_cnt++;
      case (m3_mode)
        0:       cpu_m3 = (m3_cnt % 4 == 0);
        1:       cpu_m3 = 1'b0;
        default: cpu_m3 = 1'b1;
      endcase
    end
  end

  // Per-cycle checker of the protocol rules against the bench's own model.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (done === 1'b1) done_total++;
        if (busy === 1'b1 && done !== 1'b1) work_total++;
        chk("act_follows_busy", sst_act, busy);
        if (busy !== 1'b1) begin
          chk("idle_done", done, 1'b0);
          chk("idle_sst_we", sst_we_reg, 1'b0);
          chk("idle_buf_we", buf_we, 1'b0);
        end
        if (buf_we === 1'b1 && save_mode) begin
          chk("cap_data", buf_di, buf_addr ^ 8'h5A);
          chk("cap_range", buf_addr[7], 1'b0);
        end
        if (sst_we_reg === 1'b1) begin
          chk("wr_not_map_idx", sst_addr == 8'd127, 1'b0);
          chk("wr_data", sst_dato, exp_buf(sst_addr));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic l);
    cmd_save = s;
    cmd_load = l;
    @(negedge clk);
    cmd_save = 1'b0;
    cmd_load = 1'b0;
  endtask

  task automatic fill(input int mode);
    fill_mode = mode;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic clear_map();
    map_clr = 1'b1;
    @(negedge clk);
    map_clr = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
    end
  endtask

  initial begin
    int n0, d0, w0, k;
    map_rst = 1'b1; cmd_save = 1'b0; cmd_load = 1'b0;
    map_clr = 1'b1; fill_req = 1'b1;
    tick(3);
    map_clr = 1'b0; fill_req = 1'b0;
    // Reset state
    chk("rst_busy", busy, 1'b0);         chk("rst_done", done, 1'b0);
    chk("rst_act", sst_act, 1'b0);       chk("rst_sst_we", sst_we_reg, 1'b0);
    chk("rst_buf_we", buf_we, 1'b0);     chk("rst_vfy", vfy_err, 1'b0);
    chk("rst_sst_addr", sst_addr, 8'h00); chk("rst_buf_addr", buf_addr, 8'h00);
    chk("rst_dato", sst_dato, 8'h00);    chk("rst_buf_di", buf_di, 8'h00);
    map_rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Save from the addr^5A stub
    save_mode = 1'b1;
    d0 = done_total; w0 = work_total;
    pulse(1'b1, 1'b0);
    wait_done(400);
    chk("save_busy_in_done", busy, 1'b1);
    tick(2);
    chk("save_idle_after", busy, 1'b0);
    chk("save_done_count", done_total - d0, 1);
    chk("save_busy_cycles_before_done", work_total - w0, 256);
    for (int i = 0; i < 128; i++) chk("save_buf", buf_mem[i], 8'(i) ^ 8'h5A);
    chk("save_buf0", buf_mem[0], 8'h5A);
    chk("save_buf127", buf_mem[127], 8'h25);
    chk("save_buf128_untouched", buf_mem[128], 8'h00);
    $display("save: done, %0d busy cycles", work_total - w0);

    // Load buffer[i]=i with m3 one cycle in four
    save_mode = 1'b0;
    clear_map();
    fill(0);
    m3_mode = 0;
    n0 = wr_addr_q.size(); d0 = done_total;
    pulse(1'b0, 1'b1);
    wait_done(2000);
    tick(2);
    chk("loadA_write_count", wr_addr_q.size() - n0, 127);
    for (int i = 0; i < 127; i++) begin
      if (n0 + i < wr_addr_q.size()) begin
        chk("loadA_addr", wr_addr_q[n0 + i], 8'(i));
        chk("loadA_data", wr_data_q[n0 + i], 8'(i));
      end
    end
    chk("loadA_reg127_untouched", map_regs[127], 8'hC3);
    chk("loadA_done_count", done_total - d0, 1);
`ifndef SST_VERIFY_EN
    chk("vfy_tied_low", vfy_err, 1'b0);
`endif
    $display("loadA: %0d writes", wr_addr_q.size() - n0);

    // Load with m3 held low: write must hold at index 0
    clear_map();
    fill(1);
    m3_mode = 1;
    n0 = wr_addr_q.size();
    pulse(1'b0, 1'b1);
    k = 0;
    while (sst_we_reg !== 1'b1 && k < 10) begin tick(1); k++; end
    for (int i = 0; i < 50; i++) begin
      chk("stall_we", sst_we_reg, 1'b1);
      chk("stall_addr", sst_addr, 8'h00);
      chk("stall_dato", sst_dato, 8'h33);
      tick(1);
    end
    m3_mode = 2;
    tick(1);
    m3_mode = 1;
    chk("m3_cycle_we", sst_we_reg, 1'b1);
    tick(1);
    chk("after_m3_we_low", sst_we_reg, 1'b0);
    chk("after_m3_idx", sst_addr, 8'h01);
    tick(1);
    chk("next_we", sst_we_reg, 1'b1);
    chk("next_addr", sst_addr, 8'h01);
    chk("next_dato", sst_dato, 8'h32);
    chk("stall_one_write", wr_addr_q.size() - n0, 1);
    if (wr_addr_q.size() > n0) chk("stall_first_write", wr_data_q[n0], 8'h33);
    m3_mode = 2;
    wait_done(1000);
    tick(2);
    chk("loadB_reg126", map_regs[126], 8'h4D);
    chk("loadB_reg127_untouched", map_regs[127], 8'hC3);
    $display("loadB: stall held 50 cycles, %0d writes", wr_addr_q.size() - n0);

    // Reset mid-load at index 40
    fill(0);
    m3_mode = 0;
    pulse(1'b0, 1'b1);
    k = 0;
    while (!(sst_we_reg === 1'b1 && sst_addr == 8'd40) && k < 2000) begin tick(1); k++; end
    chk("rst_mid_reached_40", sst_addr, 8'd40);
    d0 = done_total;
    map_rst = 1'b1;
    tick(1);
    map_rst = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);       chk("rst_mid_act", sst_act, 1'b0);
    chk("rst_mid_we", sst_we_reg, 1'b0);   chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_addr", sst_addr, 8'h00);  chk("rst_mid_dato", sst_dato, 8'h00);
    tick(5);
    chk("rst_mid_no_done", done_total - d0, 0);
    save_mode = 1'b1;
    pulse(1'b1, 1'b0);
    chk("save_after_rst_busy", busy, 1'b1);
    chk("save_after_rst_idx", sst_addr, 8'h00);
    tick(1);
    chk("save_after_rst_cap", buf_we, 1'b1);
    chk("save_after_rst_buf_addr", buf_addr, 8'h00);
    chk("save_after_rst_buf_di", buf_di, 8'h5A);
    wait_done(400);
    tick(2);
    $display("reset mid-load: recovered, save restarted at idx 0");

    // Simultaneous commands and a load during a save
    fill(2);
    n0 = wr_addr_q.size(); d0 = done_total; w0 = work_total;
    pulse(1'b1, 1'b1);
    chk("both_cmd_busy", busy, 1'b1);
    chk("both_cmd_no_sst_we", sst_we_reg, 1'b0);
    tick(1);
    chk("both_cmd_is_save", buf_we, 1'b1);
    tick(48);
    pulse(1'b0, 1'b1);
    wait_done(400);
    tick(2);
    chk("both_cmd_no_writes", wr_addr_q.size() - n0, 0);
    chk("both_cmd_done_count", done_total - d0, 1);
    chk("both_cmd_busy_cycles", work_total - w0, 256);
    chk("both_cmd_buf5", buf_mem[5], 8'h5F);
    $display("save+load together: ran save, mid-save load ignored");

`ifdef SST_VERIFY_EN
    // Verify pass: corrupted reg 9 must flag, intact regs must not
    save_mode = 1'b0;
    fill(1);
    m3_mode = 2;
    corrupt = 1'b1;
    pulse(1'b0, 1'b1);
    wait_done(1500);
    chk("vfy_corrupt_flag", vfy_err, 1'b1);
    tick(2);
    corrupt = 1'b0;
    pulse(1'b0, 1'b1);
    chk("vfy_clear_on_load", vfy_err, 1'b0);
    wait_done(1500);
    chk("vfy_clean_flag", vfy_err, 1'b0);
    tick(2);
    corrupt = 1'b1;
    pulse(1'b0, 1'b1);
    wait_done(1500);
    chk("vfy_corrupt_again", vfy_err, 1'b1);
    map_rst = 1'b1;
    tick(1);
    map_rst = 1'b0;
    chk("vfy_clear_on_rst", vfy_err, 1'b0);
    corrupt = 1'b0;
    $display("verify: corrupted and clean passes checked");
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
